// File: rtl/ring_hop_router_pkg.sv
// ring_hop_router_pkg: ring direction type and hop-field width helper for ring_hop_router
package ring_hop_router_pkg;

    typedef enum logic {
        RingLeft  = 1'b0,
        RingRight = 1'b1
    } ring_dir_e;

    function automatic int ring_hop_width(int nr_clusters);
        return nr_clusters > 1 ? $clog2(nr_clusters) : 1;
    endfunction

endpackage

// File: rtl/ring_hop_router_fifo.sv
// ring_hop_router_fifo: registered FIFO without fall-through, one per router queue
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
//        pop_i/data_o read side (data_o is the head entry); empty_o/full_o registered flags.
module ring_hop_router_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AddrW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [AddrW-1:0] LastPtr = AddrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AddrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    always_comb begin
        do_pop = pop_i && cnt_q != '0;
        // a full queue still takes a push in the cycle its head leaves
        do_push = push_i && (cnt_q != FullCnt || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = data_i;
        wr_d = do_push ? (wr_q == LastPtr ? '0 : wr_q + AddrW'(1)) : wr_q;
        rd_d = do_pop ? (rd_q == LastPtr ? '0 : rd_q + AddrW'(1)) : rd_q;
        cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    assign data_o = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign full_o = cnt_q == FullCnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ring_hop_router.sv
// ring_hop_router: hop-counted ring node between the local SLDU and its two ring neighbours
// Ports: clk_i/rst_ni clock and async active-low reset; cfg_* direction and hop distance,
//        accepted only when the router is idle; sldu_* injection from / ejection to the local SLDU;
//        ring_{left,right}_{i,o} flits {hops, data} from / to the neighbours, valid/ready handshaked.
module ring_hop_router
    import ring_hop_router_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int NrClusters = 4,
    parameter int FifoDepth = 2,
    localparam int HopW = ring_hop_width(NrClusters),
    localparam int FlitW = DataWidth + HopW
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  ring_dir_e            cfg_dir_i,
    input  logic [HopW-1:0]      cfg_hops_i,
    input  logic [DataWidth-1:0] sldu_i,
    input  logic                 sldu_valid_i,
    output logic                 sldu_ready_o,
    output logic [DataWidth-1:0] sldu_o,
    output logic                 sldu_valid_o,
    input  logic                 sldu_ready_i,
    input  logic [FlitW-1:0]     ring_left_i,
    input  logic                 ring_left_valid_i,
    output logic                 ring_left_ready_o,
    input  logic [FlitW-1:0]     ring_right_i,
    input  logic                 ring_right_valid_i,
    output logic                 ring_right_ready_o,
    output logic [FlitW-1:0]     ring_left_o,
    output logic                 ring_left_valid_o,
    input  logic                 ring_left_ready_i,
    output logic [FlitW-1:0]     ring_right_o,
    output logic                 ring_right_valid_o,
    input  logic                 ring_right_ready_i
);
    localparam logic [HopW-1:0] MaxHop = HopW'(NrClusters - 1);

    ring_dir_e dir_q, dir_d;
    logic [HopW-1:0] hops_q, hops_d;

    logic right, in_valid, in_to_ej, in_ready, in_push, inj_to_ej, inj_push;
    logic [FlitW-1:0] in_flit, out_data;
    logic [HopW-1:0] in_hops;
    logic [DataWidth-1:0] in_data, ej_data;
    logic out_full, ej_push, out_push, l_push, r_push, l_pop, r_pop, ej_pop;
    logic l_empty, l_full, r_empty, r_full, ej_empty, ej_full, cfg_fire;

    always_comb begin
        right = dir_q == RingRight;
        in_flit = right ? ring_left_i : ring_right_i;
        in_valid = right ? ring_left_valid_i : ring_right_valid_i;
        in_hops = in_flit[FlitW-1:DataWidth];
        in_data = in_flit[DataWidth-1:0];
        in_to_ej = in_hops == '0;
        out_full = right ? r_full : l_full;
        // ready follows the queue the incoming hop field selects, so it is combinational on ring_*_i
        in_ready = in_to_ej ? !ej_full : !out_full;
        in_push = in_valid && in_ready;
        inj_to_ej = hops_q == '0;
        // ring traffic owns a queue whenever it targets it, even if it cannot push this cycle
        sldu_ready_o = !(inj_to_ej ? ej_full : out_full) && !(in_valid && in_to_ej == inj_to_ej);
        inj_push = sldu_valid_i && sldu_ready_o;
        ej_push = (in_push && in_to_ej) || (inj_push && inj_to_ej);
        ej_data = in_push && in_to_ej ? in_data : sldu_i;
        out_push = (in_push && !in_to_ej) || (inj_push && !inj_to_ej);
        out_data = in_push && !in_to_ej ? {in_hops - HopW'(1), in_data} : {hops_q - HopW'(1), sldu_i};
        l_push = out_push && !right;
        r_push = out_push && right;
        ring_left_ready_o = right && in_ready;
        ring_right_ready_o = !right && in_ready;
        ring_left_valid_o = !right && !l_empty;
        ring_right_valid_o = right && !r_empty;
        sldu_valid_o = !ej_empty;
        l_pop = ring_left_valid_o && ring_left_ready_i;
        r_pop = ring_right_valid_o && ring_right_ready_i;
        ej_pop = sldu_valid_o && sldu_ready_i;
        cfg_ready_o = l_empty && r_empty && ej_empty && !in_valid && !sldu_valid_i;
        cfg_fire = cfg_valid_i && cfg_ready_o;
        dir_d = cfg_fire ? cfg_dir_i : dir_q;
        hops_d = cfg_fire ? (cfg_hops_i > MaxHop ? MaxHop : cfg_hops_i) : hops_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q <= RingLeft;
            hops_q <= '0;
        end else begin
            dir_q <= dir_d;
            hops_q <= hops_d;
        end
    end

    ring_hop_router_fifo #(.Width(FlitW), .Depth(FifoDepth)) i_fifo_left (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(l_push), .data_i(out_data), .pop_i(l_pop),
        .data_o(ring_left_o), .empty_o(l_empty), .full_o(l_full)
    );

    ring_hop_router_fifo #(.Width(FlitW), .Depth(FifoDepth)) i_fifo_right (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(r_push), .data_i(out_data), .pop_i(r_pop),
        .data_o(ring_right_o), .empty_o(r_empty), .full_o(r_full)
    );

    ring_hop_router_fifo #(.Width(DataWidth), .Depth(FifoDepth)) i_fifo_ej (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(ej_push), .data_i(ej_data), .pop_i(ej_pop),
        .data_o(sldu_o), .empty_o(ej_empty), .full_o(ej_full)
    );

    // the neighbour on the inactive side must stay silent
    a_inactive_quiet: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(right ? ring_right_valid_i : ring_left_valid_i));

endmodule
